instr_encoder: RTL and testbench
================================

INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 clk  input  1  system clock; all state updates on rising edge.
REQ-002 rst  input  1  synchronous, active-high reset.
REQ-003 in_valid  input  1  producer presents a field set to encode.
REQ-004 in_ready  output  1  encoder can accept a field set this cycle.
REQ-005 in_fmt  input  3  format: 0=R, 1=I, 2=S, 3=B, 4=U, 5=J, 6/7 illegal.
REQ-006 in_opcode  input  7  opcode, placed in bits [6:0].
REQ-007 in_funct3  input  3  funct3, placed in bits [14:12] (R/I/S/B only).
REQ-008 in_funct7  input  7  funct7, placed in bits [31:25] (R only).
REQ-009 in_rd, in_rs1, in_rs2  input  5 each  register indices.
REQ-010 in_imm  input  32  sign-extended immediate, byte offset for B/J.
REQ-011 in_swap  input  1  store the word byte-swapped (big-endian image), sampled at accept.
REQ-012 out_valid  output  1  head FIFO entry is valid.
REQ-013 out_ready  input  1  consumer takes the head entry.
REQ-014 out_instr  output  32  encoded instruction word at FIFO head.
REQ-015 out_err  output  1  head entry was an illegal or misaligned request.
REQ-016 out_count  output  16  number of entries popped since reset.

Function
REQ-017 Accept occurs when in_valid && in_ready at a rising edge; the encoded word plus its err bit is written into a 2-entry FIFO.
REQ-018 in_ready SHALL be 1 exactly when the FIFO holds fewer than 2 entries; it has no same-cycle bypass from a pop.
REQ-019 Latency: an entry accepted at edge N SHALL appear at the head of an empty FIFO with out_valid=1 in the cycle after edge N.
REQ-020 Pop occurs when out_valid && out_ready; simultaneous accept and pop with 1 entry held SHALL leave occupancy at 1 and preserve order.
REQ-021 out_instr/out_err SHALL hold stable while out_valid=1 and out_ready=0.
REQ-022 R format: {funct7, rs2, rs1, funct3, rd, opcode}.
REQ-023 I format: {imm[11:0], rs1, funct3, rd, opcode}.
REQ-024 S format: {imm[11:5], rs2, funct3-adjacent rs1 order as {rs2, rs1, funct3}, imm[4:0], opcode}.
REQ-025 B format: {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode}.
REQ-026 U format: {imm[31:12], rd, opcode}.
REQ-027 J format: {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode}.
REQ-028 Illegal fmt (6/7), or fmt B/J with in_imm[0]=1, SHALL store word 0x00000013 (NOP) with err=1; the word is still subject to in_swap.
REQ-029 With in_swap=1, the stored word SHALL be {w[7:0], w[15:8], w[23:16], w[31:24]}.
REQ-030 out_count SHALL increment by 1 on each pop and wrap from 0xFFFF to 0x0000.
REQ-031 Immediate bits not used by the selected format SHALL be ignored; no range check beyond REQ-028.

Reset
REQ-032 On rst=1 at an edge: FIFO emptied, out_valid=0, out_err=0, out_instr=0, out_count=0, in_ready=1 in the following cycle.
REQ-033 rst SHALL take priority over a simultaneous accept or pop; in-flight entries are discarded.
REQ-034 in_ready SHALL be 1 during and after reset; accepts presented while rst=1 are dropped.

Verification
REQ-035 I: opcode 0x13, funct3 0, rd 1, rs1 0, imm 5, swap 0 -> out_instr 0x00500093, err 0, one cycle after accept.
REQ-036 Same request with swap 1 -> 0x93005000.
REQ-037 S: opcode 0x23, funct3 2, rs1 1, rs2 2, imm 8 -> 0x0020A423; J: opcode 0x6F, rd 0, imm -4 -> 0xFFDFF06F.
REQ-038 B with imm 3 -> 0x00000013, err 1; fmt 7 -> 0x00000013, err 1.
REQ-039 Back-pressure: hold out_ready=0 and offer 3 requests -> in_ready drops after 2 accepts; then release -> 3 words out in order, out_count=3.
REQ-040 Reset asserted with 2 entries held -> next cycle out_valid=0, out_count=0, in_ready=1.

Source files
------------

// File: rtl/instr_encoder_if.sv
// Request/response bundle for the instruction encoder.
// The producer side presents field sets; the consumer side drains encoded words.
interface instr_encoder_if;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_fmt;
  logic [6:0]  in_opcode;
  logic [2:0]  in_funct3;
  logic [6:0]  in_funct7;
  logic [4:0]  in_rd;
  logic [4:0]  in_rs1;
  logic [4:0]  in_rs2;
  logic [31:0] in_imm;
  logic        in_swap;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic        out_err;
  logic [15:0] out_count;

  // Environment side: drives requests and the consumer ready.
  modport master (
    output in_valid, in_fmt, in_opcode, in_funct3, in_funct7,
           in_rd, in_rs1, in_rs2, in_imm, in_swap, out_ready,
    input  in_ready, out_valid, out_instr, out_err, out_count
  );

  // Encoder side.
  modport slave (
    input  in_valid, in_fmt, in_opcode, in_funct3, in_funct7,
           in_rd, in_rs1, in_rs2, in_imm, in_swap, out_ready,
    output in_ready, out_valid, out_instr, out_err, out_count
  );
endinterface

// File: rtl/instr_encoder.sv
// RV32 instruction encoder: packs a field set into a 32-bit word according
// to its format, optionally byte-swaps it, and queues it in a 2-entry FIFO.
module instr_encoder (
  input  logic           clk,
  input  logic           rst,
  instr_encoder_if.slave bus
);
  localparam logic [31:0] NOP_WORD = 32'h0000_0013;

  logic [31:0] word_next;
  logic        err_next;
  logic [31:0] store_word;
  logic [31:0] swap_word;

  logic [31:0] instr_mem_reg [2];
  logic [1:0]  err_mem_reg;
  logic        wr_ptr_reg;
  logic        rd_ptr_reg;
  logic [1:0]  count_reg;
  logic [15:0] pop_count_reg;

  logic accept;
  logic pop;

  // Format-dependent field packing; illegal or misaligned requests become a flagged NOP.
  always_comb begin
    word_next = NOP_WORD;
    err_next  = 1'b0;
    case (bus.in_fmt)
      3'd0: word_next = {bus.in_funct7, bus.in_rs2, bus.in_rs1, bus.in_funct3,
                         bus.in_rd, bus.in_opcode};
      3'd1: word_next = {bus.in_imm[11:0], bus.in_rs1, bus.in_funct3,
                         bus.in_rd, bus.in_opcode};
      3'd2: word_next = {bus.in_imm[11:5], bus.in_rs2, bus.in_rs1, bus.in_funct3,
                         bus.in_imm[4:0], bus.in_opcode};
      3'd3: begin
        if (bus.in_imm[0]) begin
          err_next = 1'b1;
        end else begin
          word_next = {bus.in_imm[12], bus.in_imm[10:5], bus.in_rs2, bus.in_rs1,
                       bus.in_funct3, bus.in_imm[4:1], bus.in_imm[11], bus.in_opcode};
        end
      end
      3'd4: word_next = {bus.in_imm[31:12], bus.in_rd, bus.in_opcode};
      3'd5: begin
        if (bus.in_imm[0]) begin
          err_next = 1'b1;
        end else begin
          word_next = {bus.in_imm[20], bus.in_imm[10:1], bus.in_imm[11],
                       bus.in_imm[19:12], bus.in_rd, bus.in_opcode};
        end
      end
      default: err_next = 1'b1;
    endcase
  end

  // Big-endian image: byte gi of the result is byte (3-gi) of the encoded word.
  for (genvar gi = 0; gi < 4; gi++) begin : g_swap
    assign swap_word[8*gi +: 8] = word_next[8*(3-gi) +: 8];
  end

  assign store_word = bus.in_swap ? swap_word : word_next;

  // Capacity check only; reset priority is handled in the state register.
  assign accept = bus.in_valid && (count_reg != 2'd2);
  assign pop    = (count_reg != 2'd0) && bus.out_ready;

  assign bus.in_ready  = rst || (count_reg != 2'd2);
  assign bus.out_valid = (count_reg != 2'd0);
  assign bus.out_instr = (count_reg != 2'd0) ? instr_mem_reg[rd_ptr_reg] : 32'd0;
  assign bus.out_err   = (count_reg != 2'd0) ? err_mem_reg[rd_ptr_reg] : 1'b0;
  assign bus.out_count = pop_count_reg;

  // Entry storage; contents are only observed through the occupancy gate, so no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      instr_mem_reg[wr_ptr_reg] <= store_word;
      err_mem_reg[wr_ptr_reg]   <= err_next;
    end
  end

  // Pointers, occupancy and pop counter; reset discards anything in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg    <= 1'b0;
      rd_ptr_reg    <= 1'b0;
      count_reg     <= 2'd0;
      pop_count_reg <= 16'd0;
    end else begin
      if (accept) wr_ptr_reg <= ~wr_ptr_reg;
      if (pop) begin
        rd_ptr_reg    <= ~rd_ptr_reg;
        pop_count_reg <= pop_count_reg + 16'd1;
      end
      case ({accept, pop})
        2'b10:   count_reg <= count_reg + 2'd1;
        2'b01:   count_reg <= count_reg - 2'd1;
        default: count_reg <= count_reg;
      endcase
    end
  end
endmodule

// File: tb/tb_instr_encoder.sv
// Bench for instr_encoder: directed vector table, hand-built back-pressure and
// reset sequences, then random traffic against a queue-based reference model.
module tb_instr_encoder;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  instr_encoder_if bus();

  instr_encoder dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [2:0]  fmt;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    logic        swap;
    logic [31:0] exp_instr;
    logic        exp_err;
  } vec_t;

  vec_t vecs [10];

  logic [32:0] model_q [$];
  logic [15:0] model_cnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Reference encoder: places each field at its bit offset with shifts and masks.
  function automatic logic [32:0] model_encode(
    input logic [2:0] fmt, input logic [6:0] op, input logic [2:0] f3,
    input logic [6:0] f7, input logic [4:0] rd, input logic [4:0] rs1,
    input logic [4:0] rs2, input logic [31:0] imm, input logic swap);
    logic [31:0] w;
    logic [31:0] base_r;
    logic        err;
    err    = (fmt > 3'd5) || ((fmt == 3'd3 || fmt == 3'd5) && imm[0]);
    base_r = 32'(op) | (32'(f3) << 12) | (32'(rs1) << 15);
    case (fmt)
      3'd0: w = base_r | (32'(rd) << 7) | (32'(rs2) << 20) | (32'(f7) << 25);
      3'd1: w = base_r | (32'(rd) << 7) | ((imm & 32'hFFF) << 20);
      3'd2: w = base_r | ((imm & 32'h1F) << 7) | (32'(rs2) << 20)
                | (((imm >> 5) & 32'h7F) << 25);
      3'd3: w = base_r | (((imm >> 11) & 32'h1) << 7) | (((imm >> 1) & 32'hF) << 8)
                | (32'(rs2) << 20) | (((imm >> 5) & 32'h3F) << 25)
                | (((imm >> 12) & 32'h1) << 31);
      3'd4: w = 32'(op) | (32'(rd) << 7) | (imm & 32'hFFFF_F000);
      3'd5: w = 32'(op) | (32'(rd) << 7) | (((imm >> 12) & 32'hFF) << 12)
                | (((imm >> 11) & 32'h1) << 20) | (((imm >> 1) & 32'h3FF) << 21)
                | (((imm >> 20) & 32'h1) << 31);
      default: w = 32'h13;
    endcase
    if (err) w = 32'h13;
    if (swap)
      w = ((w & 32'hFF) << 24) | (((w >> 8) & 32'hFF) << 16)
          | (((w >> 16) & 32'hFF) << 8) | ((w >> 24) & 32'hFF);
    return {err, w};
  endfunction

  task automatic drive_req(input logic [2:0] fmt, input logic [6:0] op, input logic [2:0] f3,
                           input logic [6:0] f7, input logic [4:0] rd, input logic [4:0] rs1,
                           input logic [4:0] rs2, input logic [31:0] imm, input logic swap);
    bus.in_fmt    = fmt;
    bus.in_opcode = op;
    bus.in_funct3 = f3;
    bus.in_funct7 = f7;
    bus.in_rd     = rd;
    bus.in_rs1    = rs1;
    bus.in_rs2    = rs2;
    bus.in_imm    = imm;
    bus.in_swap   = swap;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Directed vectors: fmt op f3 f7 rd rs1 rs2 imm swap -> instr err
    vecs[0] = '{3'd1, 7'h13, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 32'd5,        1'b0, 32'h0050_0093, 1'b0};
    vecs[1] = '{3'd1, 7'h13, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 32'd5,        1'b1, 32'h9300_5000, 1'b0};
    vecs[2] = '{3'd2, 7'h23, 3'd2, 7'h00, 5'd0, 5'd1, 5'd2, 32'd8,        1'b0, 32'h0020_A423, 1'b0};
    vecs[3] = '{3'd5, 7'h6F, 3'd0, 7'h00, 5'd0, 5'd0, 5'd0, 32'hFFFF_FFFC, 1'b0, 32'hFFDF_F06F, 1'b0};
    vecs[4] = '{3'd3, 7'h63, 3'd0, 7'h00, 5'd0, 5'd1, 5'd2, 32'd3,        1'b0, 32'h0000_0013, 1'b1};
    vecs[5] = '{3'd7, 7'h33, 3'd0, 7'h00, 5'd3, 5'd1, 5'd2, 32'd0,        1'b0, 32'h0000_0013, 1'b1};
    vecs[6] = '{3'd0, 7'h33, 3'd0, 7'h00, 5'd3, 5'd1, 5'd2, 32'd0,        1'b0, 32'h0020_81B3, 1'b0};
    vecs[7] = '{3'd4, 7'h37, 3'd0, 7'h00, 5'd5, 5'd0, 5'd0, 32'h1234_5678, 1'b0, 32'h1234_52B7, 1'b0};
    vecs[8] = '{3'd3, 7'h63, 3'd0, 7'h00, 5'd0, 5'd1, 5'd2, 32'd8,        1'b0, 32'h0020_8463, 1'b0};
    vecs[9] = '{3'd5, 7'h6F, 3'd0, 7'h00, 5'd0, 5'd0, 5'd0, 32'd1,        1'b1, 32'h1300_0000, 1'b1};

    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    drive_req(3'd0, 7'd0, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'd0, 1'b0);
    tick();
    tick();
    chk("rst_in_ready_during", bus.in_ready, 1'b1);
    rst = 1'b0;
    tick();
    chk("rst_out_valid", bus.out_valid, 1'b0);
    chk("rst_out_err", bus.out_err, 1'b0);
    chk("rst_out_instr", bus.out_instr, 32'd0);
    chk("rst_out_count", bus.out_count, 16'd0);
    chk("rst_in_ready", bus.in_ready, 1'b1);

    // Table: each request must show at the head one cycle after acceptance.
    for (int i = 0; i < 10; i++) begin
      drive_req(vecs[i].fmt, vecs[i].op, vecs[i].f3, vecs[i].f7, vecs[i].rd,
                vecs[i].rs1, vecs[i].rs2, vecs[i].imm, vecs[i].swap);
      bus.in_valid = 1'b1;
      tick();
      bus.in_valid = 1'b0;
      $display("vec %0d fmt=%0d instr=0x%08h err=%0b", i, vecs[i].fmt, bus.out_instr, bus.out_err);
      chk($sformatf("vec%0d_valid", i), bus.out_valid, 1'b1);
      chk($sformatf("vec%0d_instr", i), bus.out_instr, vecs[i].exp_instr);
      chk($sformatf("vec%0d_err", i), bus.out_err, vecs[i].exp_err);
      bus.out_ready = 1'b1;
      tick();
      bus.out_ready = 1'b0;
      chk($sformatf("vec%0d_count", i), bus.out_count, 16'(i + 1));
    end

    // Reset with two entries held, colliding with an accept and a pop.
    drive_req(3'd1, 7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd7, 1'b0);
    bus.in_valid = 1'b1;
    tick();
    tick();
    chk("full_in_ready", bus.in_ready, 1'b0);
    rst           = 1'b1;
    bus.out_ready = 1'b1;
    #1;
    chk("rst_full_in_ready_during", bus.in_ready, 1'b1);
    tick();
    chk("rst_full_out_valid", bus.out_valid, 1'b0);
    chk("rst_full_out_count", bus.out_count, 16'd0);
    chk("rst_full_in_ready", bus.in_ready, 1'b1);
    tick();
    rst = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    #1;
    chk("rst_drop_out_valid", bus.out_valid, 1'b0);
    $display("reset with full fifo: out_valid=%0b count=%0d", bus.out_valid, bus.out_count);

    // Back-pressure: three I-type requests (imm 1,2,3) with the consumer stalled.
    bus.in_valid = 1'b1;
    drive_req(3'd1, 7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd1, 1'b0);
    tick();
    chk("bp_ready_after1", bus.in_ready, 1'b1);
    drive_req(3'd1, 7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd2, 1'b0);
    tick();
    chk("bp_ready_after2", bus.in_ready, 1'b0);
    drive_req(3'd1, 7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd3, 1'b0);
    tick();
    chk("bp_ready_stall", bus.in_ready, 1'b0);
    chk("bp_head_stable", bus.out_instr, 32'h0010_0093);
    bus.out_ready = 1'b1;
    tick();
    $display("bp pop word=0x%08h count=%0d", bus.out_instr, bus.out_count);
    chk("bp_word2", bus.out_instr, 32'h0020_0093);
    chk("bp_ready_reopen", bus.in_ready, 1'b1);
    tick();
    bus.in_valid = 1'b0;
    $display("bp pop word=0x%08h count=%0d", bus.out_instr, bus.out_count);
    chk("bp_word3", bus.out_instr, 32'h0030_0093);
    chk("bp_valid3", bus.out_valid, 1'b1);
    tick();
    bus.out_ready = 1'b0;
    chk("bp_empty", bus.out_valid, 1'b0);
    chk("bp_count", bus.out_count, 16'd3);

    // Random traffic against the queue model.
    model_cnt = 16'd3;
    for (int c = 0; c < 600; c++) begin
      logic [32:0] exp_entry;
      logic        acc;
      logic        pp;
      chk("rnd_out_valid", bus.out_valid, model_q.size() != 0);
      chk("rnd_in_ready", bus.in_ready, model_q.size() < 2);
      chk("rnd_count", bus.out_count, model_cnt);
      if (model_q.size() != 0) begin
        chk("rnd_instr", bus.out_instr, model_q[0][31:0]);
        chk("rnd_err", bus.out_err, model_q[0][32]);
      end
      drive_req(3'($urandom_range(0, 7)), 7'($urandom), 3'($urandom), 7'($urandom),
                5'($urandom), 5'($urandom), 5'($urandom),
                ($urandom_range(0, 3) == 0) ? $urandom : ($urandom & 32'hFFFF_FFFE),
                1'($urandom));
      bus.in_valid  = 1'($urandom);
      bus.out_ready = ($urandom_range(0, 3) != 0);
      acc = bus.in_valid && (model_q.size() < 2);
      pp  = (model_q.size() != 0) && bus.out_ready;
      exp_entry = model_encode(bus.in_fmt, bus.in_opcode, bus.in_funct3, bus.in_funct7,
                               bus.in_rd, bus.in_rs1, bus.in_rs2, bus.in_imm, bus.in_swap);
      if (pp) $display("rnd pop word=0x%08h err=%0b", bus.out_instr, bus.out_err);
      tick();
      if (pp) begin
        void'(model_q.pop_front());
        model_cnt = model_cnt + 16'd1;
      end
      if (acc) model_q.push_back(exp_entry);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
